ctrl_pipe_hazard: RTL and testbench
===================================

// Module: ctrl_pipe_hazard
// PURPOSE
//  Receiving end of the decoder's control bundle. Carries EX/M/WB control fields through ID/EX, EX/MEM, MEM/WB.
//  Detects load-use hazards (stall + bubble), applies branch flush, generates EX forwarding selects.
//  Drains the pipeline on halt. Sits between the control decoder (ID) and the EX/MEM/WB datapath.
// PARAMETERS
//  N_BITS      32  instruction width
//  N_BITS_REG  5   register-address width
// PORTS
//  i_clk           in   1        single clock, rising edge
//  i_reset         in   1        asynchronous, active-low reset
//  i_valid         in   1        pipeline advance enable; 0 = every register holds
//  i_halt          in   1        instruction at ID is HALT
//  i_instruccion   in   N_BITS   instruction at ID (rs=[25:21], rt=[20:16], rd=[15:11])
//  i_ALUOp,i_ALUSrc,i_regDst  in  2,1,1  EX control from decoder
//  i_branch,i_memRead,i_memWrite  in  2,1,1  MEM control from decoder
//  i_memtoReg,i_regWrite  in  1,1  WB control from decoder
//  i_branch_taken  in   1        branch/jump resolved taken in MEM stage
//  o_EX_ALUOp,o_EX_ALUSrc,o_EX_regDst  out  2,1,1  ID/EX register contents
//  o_M_branch,o_M_memRead,o_M_memWrite  out  2,1,1  EX/MEM register contents
//  o_WB_memtoReg,o_WB_regWrite  out  1,1  MEM/WB register contents
//  o_wb_rd         out  N_BITS_REG  MEM/WB destination register
//  o_fwd_a,o_fwd_b out  2        EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  o_stall         out  1        hold PC and IF/ID
//  o_flush         out  1        clear IF/ID
//  o_halted        out  1        HALT reached WB; sticky
// BEHAVIOUR
//  - Reset (i_reset=0, async): all stage registers, valid bits, halt tokens, o_halted cleared; all outputs 0.
//  - Latency: bundle accepted at ID in cycle t -> EX outputs t+1, MEM t+2, WB t+3 (i_valid=1 throughout).
//  - Each stage holds: ctrl fields, valid, halt token, rs, rt, dest. dest = regDst ? rd : rt.
//  - i_valid=0: no register updates; comb outputs are recomputed from held state.
//  - Load-use: ID/EX.valid & memRead & ID/EX.dest!=0 & (dest==ID.rs | dest==ID.rt)
//    -> o_stall=1, bubble (all ctrl 0, valid 0) into ID/EX. EX/MEM and MEM/WB advance. Lasts exactly 1 cycle.
//  - Flush: i_branch_taken=1 -> o_flush=1, o_stall=0; ID/EX and EX/MEM load bubbles next edge; MEM/WB advances.
//  - Priority: reset > flush > halt-accept > load-use stall > normal.
//  - Halt: i_halt & i_valid & no flush -> bubble with halt token into ID/EX.
//    o_stall then held 1 until reset. Token reaches WB 3 advances later -> o_halted=1 (sticky).
//    i_halt in the same cycle as a flush -> discarded (wrong path).
//  - Forwarding (comb, from ID/EX.rs/rt):
//    10 if EX/MEM.regWrite & EX/MEM.dest!=0 & match;
//    else 01 if MEM/WB.regWrite & MEM/WB.dest!=0 & match;
//    else 00. EX/MEM wins over MEM/WB.
//  - Register 0 never creates a hazard or forward.
//  - Bubbles carry regWrite=memWrite=memRead=0, so they never cause side effects.
// STRUCTURE
//  - ctrl_pkg: bundle field widths, FWD_REG=2'b00 / FWD_EXMEM=2'b10 / FWD_MEMWB=2'b01, bubble constant.
//  - Sub-module ctrl_stage_reg: one pipeline register with enable, sync clear (bubble), async active-low reset.
//    Instantiated 3x. Hazard/forward logic stays in the top module.
// TESTING
//  1 Reset mid-stream: i_reset=0 for 1 cycle with all stages full
//    -> all outputs 0 immediately; o_halted=0.
//  2 R-type add $3 at t, ALUOp=00, regWrite=1
//    -> o_EX_* at t+1, o_M_* at t+2, o_WB_regWrite=1 and o_wb_rd=3 at t+3.
//  3 lw $2 followed by add $4,$2,$5
//    -> o_stall=1 for exactly one cycle, one bubble in EX; then o_fwd_a=01.
//  4 add $1; add $6,$1,$1
//    -> o_fwd_a=o_fwd_b=10 while 2nd is in EX. Same with dest $0 -> fwd=00.
//  5 beq with i_branch_taken=1 in MEM while load-use condition holds
//    -> o_flush=1, o_stall=0; next EX and MEM ctrl all 0.
//  6 HALT at t with i_valid toggling 1,0,1,1,1
//    -> o_halted rises after 3 valid advances; o_stall=1 from t on; i_valid=0 freezes progress.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle types and constants for the ID -> EX -> MEM -> WB control pipeline.
package ctrl_pkg;

    localparam int ALUOP_W  = 2;
    localparam int BRANCH_W = 2;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic [ALUOP_W-1:0]  alu_op;
        logic                alu_src;
        logic                reg_dst;
        logic [BRANCH_W-1:0] branch;
        logic                mem_read;
        logic                mem_write;
        logic                memto_reg;
        logic                reg_write;
    } ctrl_t;

    // A bubble must never write a register or touch memory.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register: holds when disabled, loads zero (bubble) on clear, async active-low reset.
module ctrl_stage_reg #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] data_q;

    // Clear only takes effect on an advancing cycle, so a held pipeline keeps its contents.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            data_q <= '0;
        end else if (i_en) begin
            data_q <= i_clr ? '0 : i_d;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall, branch flush,
// EX operand forwarding selects and halt draining.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_BITS_REG = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_halt,
    input  logic [N_BITS-1:0]     i_instruccion,
    input  logic [ALUOP_W-1:0]    i_ALUOp,
    input  logic                  i_ALUSrc,
    input  logic                  i_regDst,
    input  logic [BRANCH_W-1:0]   i_branch,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic                  i_memtoReg,
    input  logic                  i_regWrite,
    input  logic                  i_branch_taken,
    output logic [ALUOP_W-1:0]    o_EX_ALUOp,
    output logic                  o_EX_ALUSrc,
    output logic                  o_EX_regDst,
    output logic [BRANCH_W-1:0]   o_M_branch,
    output logic                  o_M_memRead,
    output logic                  o_M_memWrite,
    output logic                  o_WB_memtoReg,
    output logic                  o_WB_regWrite,
    output logic [N_BITS_REG-1:0] o_wb_rd,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic                  o_stall,
    output logic                  o_flush,
    output logic                  o_halted
);

    typedef struct packed {
        ctrl_t                 ctrl;
        logic                  valid;
        logic                  halt;
        logic [N_BITS_REG-1:0] rs;
        logic [N_BITS_REG-1:0] rt;
        logic [N_BITS_REG-1:0] dest;
    } stage_t;

    localparam int STAGE_W  = $bits(stage_t);
    localparam int N_STAGES = 3;
    localparam int IDEX     = 0;
    localparam int EXMEM    = 1;
    localparam int MEMWB    = 2;

    stage_t              stage_d [N_STAGES];
    stage_t              stage_q [N_STAGES];
    logic [N_STAGES-1:0] stage_clr;

    stage_t                id_bundle;
    stage_t                halt_bubble;
    logic [N_BITS_REG-1:0] id_rs;
    logic [N_BITS_REG-1:0] id_rt;
    logic [N_BITS_REG-1:0] id_rd;

    logic flush;
    logic load_use;
    logic halt_accept;
    logic halt_seen_q, halt_seen_d;
    logic halted_q, halted_d;

    assign id_rs = i_instruccion[21 +: N_BITS_REG];
    assign id_rt = i_instruccion[16 +: N_BITS_REG];
    assign id_rd = i_instruccion[11 +: N_BITS_REG];

    always_comb begin
        id_bundle                = '0;
        id_bundle.ctrl.alu_op    = i_ALUOp;
        id_bundle.ctrl.alu_src   = i_ALUSrc;
        id_bundle.ctrl.reg_dst   = i_regDst;
        id_bundle.ctrl.branch    = i_branch;
        id_bundle.ctrl.mem_read  = i_memRead;
        id_bundle.ctrl.mem_write = i_memWrite;
        id_bundle.ctrl.memto_reg = i_memtoReg;
        id_bundle.ctrl.reg_write = i_regWrite;
        id_bundle.valid          = 1'b1;
        id_bundle.rs             = id_rs;
        id_bundle.rt             = id_rt;
        id_bundle.dest           = i_regDst ? id_rd : id_rt;

        halt_bubble      = '0;
        halt_bubble.ctrl = CTRL_BUBBLE;
        halt_bubble.halt = 1'b1;
    end

    // Hazard decisions, highest priority first: flush, halt accept, load-use.
    assign flush       = i_branch_taken;
    assign load_use    = stage_q[IDEX].valid && stage_q[IDEX].ctrl.mem_read
                         && (stage_q[IDEX].dest != '0)
                         && ((stage_q[IDEX].dest == id_rs) || (stage_q[IDEX].dest == id_rt));
    assign halt_accept = i_halt && i_valid && !flush && !halt_seen_q;

    // After HALT is accepted ID keeps feeding plain bubbles while the token drains.
    assign stage_d[IDEX]    = halt_accept ? halt_bubble : id_bundle;
    assign stage_clr[IDEX]  = flush || halt_seen_q || (load_use && !halt_accept);
    assign stage_d[EXMEM]   = stage_q[IDEX];
    assign stage_clr[EXMEM] = flush;
    assign stage_d[MEMWB]   = stage_q[EXMEM];
    assign stage_clr[MEMWB] = 1'b0;

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
            ctrl_stage_reg #(
                .W(STAGE_W)
            ) u_stage (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_en    (i_valid),
                .i_clr   (stage_clr[gi]),
                .i_d     (stage_d[gi]),
                .o_q     (stage_q[gi])
            );
        end
    endgenerate

    assign halt_seen_d = halt_seen_q || halt_accept;
    assign halted_d    = halted_q || stage_q[MEMWB].halt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    // Forward selects for EX operand A (rs) and B (rt); the younger EX/MEM result wins.
    logic [N_BITS_REG-1:0] fwd_src [2];
    logic [1:0]            fwd_sel [2];

    assign fwd_src[0] = stage_q[IDEX].rs;
    assign fwd_src[1] = stage_q[IDEX].rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd_sel[gi] = FWD_REG;
                if (stage_q[EXMEM].ctrl.reg_write && (stage_q[EXMEM].dest != '0)
                    && (stage_q[EXMEM].dest == fwd_src[gi])) begin
                    fwd_sel[gi] = FWD_EXMEM;
                end else if (stage_q[MEMWB].ctrl.reg_write && (stage_q[MEMWB].dest != '0)
                    && (stage_q[MEMWB].dest == fwd_src[gi])) begin
                    fwd_sel[gi] = FWD_MEMWB;
                end
            end
        end
    endgenerate

    assign o_fwd_a = fwd_sel[0];
    assign o_fwd_b = fwd_sel[1];

    assign o_EX_ALUOp    = stage_q[IDEX].ctrl.alu_op;
    assign o_EX_ALUSrc   = stage_q[IDEX].ctrl.alu_src;
    assign o_EX_regDst   = stage_q[IDEX].ctrl.reg_dst;
    assign o_M_branch    = stage_q[EXMEM].ctrl.branch;
    assign o_M_memRead   = stage_q[EXMEM].ctrl.mem_read;
    assign o_M_memWrite  = stage_q[EXMEM].ctrl.mem_write;
    assign o_WB_memtoReg = stage_q[MEMWB].ctrl.memto_reg;
    assign o_WB_regWrite = stage_q[MEMWB].ctrl.reg_write;
    assign o_wb_rd       = stage_q[MEMWB].dest;

    assign o_stall  = !flush && (halt_seen_q || halt_accept || load_use);
    assign o_flush  = flush;
    assign o_halted = halted_q || stage_q[MEMWB].halt;

    // Opcode/funct bits and the late-stage fields that leave no further consumer.
    logic unused_bits;
    assign unused_bits = ^{i_instruccion, stage_q[MEMWB]};

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed scenarios plus randomized traffic checked against a slot-level pipeline model.
module tb_ctrl_pipe_hazard;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b1;
    logic        i_halt = 1'b0;
    logic [31:0] i_instruccion = '0;
    logic [1:0]  i_ALUOp = '0;
    logic        i_ALUSrc = 1'b0;
    logic        i_regDst = 1'b0;
    logic [1:0]  i_branch = '0;
    logic        i_memRead = 1'b0;
    logic        i_memWrite = 1'b0;
    logic        i_memtoReg = 1'b0;
    logic        i_regWrite = 1'b0;
    logic        i_branch_taken = 1'b0;

    logic [1:0] o_EX_ALUOp;
    logic       o_EX_ALUSrc, o_EX_regDst;
    logic [1:0] o_M_branch;
    logic       o_M_memRead, o_M_memWrite;
    logic       o_WB_memtoReg, o_WB_regWrite;
    logic [4:0] o_wb_rd;
    logic [1:0] o_fwd_a, o_fwd_b;
    logic       o_stall, o_flush, o_halted;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    ctrl_pipe_hazard #(.N_BITS(32), .N_BITS_REG(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_halt(i_halt),
        .i_instruccion(i_instruccion), .i_ALUOp(i_ALUOp), .i_ALUSrc(i_ALUSrc),
        .i_regDst(i_regDst), .i_branch(i_branch), .i_memRead(i_memRead),
        .i_memWrite(i_memWrite), .i_memtoReg(i_memtoReg), .i_regWrite(i_regWrite),
        .i_branch_taken(i_branch_taken),
        .o_EX_ALUOp(o_EX_ALUOp), .o_EX_ALUSrc(o_EX_ALUSrc), .o_EX_regDst(o_EX_regDst),
        .o_M_branch(o_M_branch), .o_M_memRead(o_M_memRead), .o_M_memWrite(o_M_memWrite),
        .o_WB_memtoReg(o_WB_memtoReg), .o_WB_regWrite(o_WB_regWrite), .o_wb_rd(o_wb_rd),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_stall(o_stall), .o_flush(o_flush),
        .o_halted(o_halted)
    );

    logic [3:0]  ex_v, m_v;
    logic [1:0]  wb_v;
    logic [21:0] all_out;
    assign ex_v    = {o_EX_ALUOp, o_EX_ALUSrc, o_EX_regDst};
    assign m_v     = {o_M_branch, o_M_memRead, o_M_memWrite};
    assign wb_v    = {o_WB_memtoReg, o_WB_regWrite};
    assign all_out = {ex_v, m_v, wb_v, o_wb_rd, o_fwd_a, o_fwd_b, o_stall, o_flush, o_halted};

    // ---------------- reference model: three slots of in-flight instructions ----------------
    typedef struct packed {
        logic       v, h;
        logic [1:0] aluop;
        logic       alusrc, regdst;
        logic [1:0] br;
        logic       mr, mw, m2r, rw;
        logic [4:0] rs, rt, dest;
    } slot_t;

    slot_t pipe [3];
    logic  m_halt_seen, m_halted;
    logic  m_lu, m_hacc, m_stall;
    logic [4:0] id_rs, id_rt, id_rd;

    assign id_rs   = i_instruccion[25:21];
    assign id_rt   = i_instruccion[20:16];
    assign id_rd   = i_instruccion[15:11];
    assign m_lu    = pipe[0].v && pipe[0].mr && pipe[0].dest != 0
                     && (pipe[0].dest == id_rs || pipe[0].dest == id_rt);
    assign m_hacc  = i_halt && i_valid && !i_branch_taken && !m_halt_seen;
    assign m_stall = !i_branch_taken && (m_halt_seen || m_hacc || m_lu);

    function automatic slot_t entering();
        slot_t s = '0;
        if (i_branch_taken) return s;
        if (m_hacc) begin
            s.h = 1'b1;
            return s;
        end
        if (m_halt_seen || m_lu) return s;
        s.v = 1'b1; s.aluop = i_ALUOp; s.alusrc = i_ALUSrc; s.regdst = i_regDst;
        s.br = i_branch; s.mr = i_memRead; s.mw = i_memWrite; s.m2r = i_memtoReg;
        s.rw = i_regWrite; s.rs = id_rs; s.rt = id_rt; s.dest = i_regDst ? id_rd : id_rt;
        return s;
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] src);
        if (pipe[1].rw && pipe[1].dest != 0 && pipe[1].dest == src) return 2'b10;
        if (pipe[2].rw && pipe[2].dest != 0 && pipe[2].dest == src) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int s = 0; s < 3; s++) pipe[s] <= '0;
            m_halt_seen <= 1'b0;
            m_halted    <= 1'b0;
        end else begin
            m_halted <= m_halted | pipe[2].h;
            if (i_valid) begin
                pipe[2] <= pipe[1];
                pipe[1] <= i_branch_taken ? '0 : pipe[0];
                pipe[0] <= entering();
                if (m_hacc) m_halt_seen <= 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic [1:0] aluop, input logic alusrc, input logic regdst,
                       input logic [1:0] br, input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        i_ALUOp = aluop; i_ALUSrc = alusrc; i_regDst = regdst; i_branch = br;
        i_memRead = mr; i_memWrite = mw; i_memtoReg = m2r; i_regWrite = rw;
        i_instruccion = {6'd0, rs, rt, rd, 11'd0};
        $display("txn t=%0t alu=%b src=%b dst=%b br=%b mr=%b mw=%b m2r=%b rw=%b rs=%0d rt=%0d rd=%0d",
                 $time, aluop, alusrc, regdst, br, mr, mw, m2r, rw, rs, rt, rd);
    endtask

    task automatic nop();
        put(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        n_checks++; if (all_out !== '0) $display("FAIL reset_init: got %h want 0", all_out); else n_pass++;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        adv();
        n_checks++; if (all_out !== '0) $display("FAIL reset_idle: got %h want 0", all_out); else n_pass++;
    endtask

    task automatic test_rtype();
        put(2'b00, 0, 1, 2'b00, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3);          // add $3,$1,$2
        adv();
        put(2'b00, 1, 0, 2'b00, 0, 1, 0, 0, 5'd8, 5'd7, 5'd0);          // sw $7
        #1;
        n_checks++; if (ex_v !== 4'b0001) $display("FAIL rtype_ex_t1: got %b want 0001", ex_v); else n_pass++;
        n_checks++; if (o_WB_regWrite !== 1'b0) $display("FAIL rtype_wb_t1: got %b want 0", o_WB_regWrite); else n_pass++;
        adv();
        nop(); #1;
        n_checks++; if (ex_v !== 4'b0010) $display("FAIL rtype_ex_t2: got %b want 0010", ex_v); else n_pass++;
        n_checks++; if (m_v !== 4'b0000) $display("FAIL rtype_m_t2: got %b want 0000", m_v); else n_pass++;
        n_checks++; if (o_WB_regWrite !== 1'b0) $display("FAIL rtype_wb_t2: got %b want 0", o_WB_regWrite); else n_pass++;
        n_checks++; if (o_fwd_a !== 2'b00) $display("FAIL rtype_fwd_t2: got %b want 00", o_fwd_a); else n_pass++;
        adv();
        n_checks++; if (wb_v !== 2'b01 || o_wb_rd !== 5'd3) $display("FAIL rtype_wb_t3: got %b rd=%0d want 01 rd=3", wb_v, o_wb_rd); else n_pass++;
        n_checks++; if (m_v !== 4'b0001) $display("FAIL rtype_m_t3: got %b want 0001", m_v); else n_pass++;
        adv();
        n_checks++; if (o_WB_regWrite !== 1'b0 || o_wb_rd !== 5'd7) $display("FAIL rtype_wb_t4: got rw=%b rd=%0d want rw=0 rd=7", o_WB_regWrite, o_wb_rd); else n_pass++;
    endtask

    task automatic test_load_use();
        put(2'b00, 1, 0, 2'b00, 1, 0, 1, 1, 5'd1, 5'd2, 5'd0);          // lw $2
        adv();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd2, 5'd5, 5'd4);          // add $4,$2,$5
        #1;
        n_checks++; if (o_stall !== 1'b1) $display("FAIL lu_stall_on: got %b want 1", o_stall); else n_pass++;
        adv();
        n_checks++; if (o_stall !== 1'b0) $display("FAIL lu_stall_once: got %b want 0", o_stall); else n_pass++;
        n_checks++; if (ex_v !== 4'b0000) $display("FAIL lu_bubble_ex: got %b want 0000", ex_v); else n_pass++;
        n_checks++; if (m_v !== 4'b0010) $display("FAIL lu_lw_mem: got %b want 0010", m_v); else n_pass++;
        adv();
        nop(); #1;
        n_checks++; if (ex_v !== 4'b1001) $display("FAIL lu_add_ex: got %b want 1001", ex_v); else n_pass++;
        n_checks++; if ({o_fwd_a, o_fwd_b} !== 4'b0100) $display("FAIL lu_fwd: got a=%b b=%b want a=01 b=00", o_fwd_a, o_fwd_b); else n_pass++;
        n_checks++; if (o_stall !== 1'b0) $display("FAIL lu_stall_after: got %b want 0", o_stall); else n_pass++;
    endtask

    task automatic test_forward();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd2, 5'd3, 5'd1);          // add $1
        adv();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd1, 5'd1, 5'd6);          // add $6,$1,$1
        adv();
        nop(); #1;
        n_checks++; if ({o_fwd_a, o_fwd_b} !== 4'b1010) $display("FAIL fwd_exmem: got a=%b b=%b want 10 10", o_fwd_a, o_fwd_b); else n_pass++;
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd9, 5'd9, 5'd1);          // two writers of $1
        adv();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd9, 5'd9, 5'd1);
        adv();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd1, 5'd1, 5'd6);
        adv();
        nop(); #1;
        n_checks++; if ({o_fwd_a, o_fwd_b} !== 4'b1010) $display("FAIL fwd_priority: got a=%b b=%b want 10 10", o_fwd_a, o_fwd_b); else n_pass++;
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd2, 5'd3, 5'd1);          // add $1; gap; use $1
        adv();
        nop();
        adv();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd1, 5'd5, 5'd6);
        adv();
        nop(); #1;
        n_checks++; if ({o_fwd_a, o_fwd_b} !== 4'b0100) $display("FAIL fwd_memwb: got a=%b b=%b want 01 00", o_fwd_a, o_fwd_b); else n_pass++;
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd2, 5'd3, 5'd0);          // add $0
        adv();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd0, 5'd0, 5'd6);          // add $6,$0,$0
        adv();
        nop(); #1;
        n_checks++; if ({o_fwd_a, o_fwd_b} !== 4'b0000) $display("FAIL fwd_r0: got a=%b b=%b want 00 00", o_fwd_a, o_fwd_b); else n_pass++;
    endtask

    task automatic test_flush();
        put(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 5'd8, 5'd9, 5'd0);          // beq
        adv();
        put(2'b00, 1, 0, 2'b00, 1, 0, 1, 1, 5'd1, 5'd2, 5'd0);          // lw $2
        adv();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd2, 5'd5, 5'd4);          // user of $2
        i_branch_taken = 1'b1;
        i_halt = 1'b1;
        #1;
        n_checks++; if ({o_flush, o_stall} !== 2'b10) $display("FAIL flush_out: got flush=%b stall=%b want 1 0", o_flush, o_stall); else n_pass++;
        adv();
        i_branch_taken = 1'b0;
        i_halt = 1'b0;
        nop(); #1;
        n_checks++; if (ex_v !== 4'b0000) $display("FAIL flush_ex: got %b want 0000", ex_v); else n_pass++;
        n_checks++; if (m_v !== 4'b0000) $display("FAIL flush_mem: got %b want 0000", m_v); else n_pass++;
        n_checks++; if ({o_flush, o_stall} !== 2'b00) $display("FAIL flush_halt_drop: got flush=%b stall=%b want 0 0", o_flush, o_stall); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        put(2'b10, 0, 1, 2'b00, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3);
        adv();
        put(2'b00, 1, 0, 2'b00, 1, 0, 1, 1, 5'd4, 5'd5, 5'd0);
        adv();
        put(2'b01, 1, 0, 2'b11, 0, 1, 0, 0, 5'd6, 5'd7, 5'd0);
        adv();
        nop();
        #1;
        i_reset = 1'b0;
        #1;
        n_checks++; if ({ex_v, m_v, wb_v, o_wb_rd} !== 15'd0) $display("FAIL rst_mid_stages: got %h want 0", {ex_v, m_v, wb_v, o_wb_rd}); else n_pass++;
        n_checks++; if ({o_fwd_a, o_fwd_b, o_stall, o_flush, o_halted} !== 7'd0) $display("FAIL rst_mid_ctrl: got %b want 0", {o_fwd_a, o_fwd_b, o_stall, o_flush, o_halted}); else n_pass++;
        #1;
        i_reset = 1'b1;
        adv();
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int n = 0; n < 200; n++) begin
            ins        = $urandom;
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            ins[15:11] = 5'($urandom_range(0, 3));
            i_instruccion  = ins;
            i_ALUOp        = 2'($urandom);
            i_ALUSrc       = 1'($urandom);
            i_regDst       = 1'($urandom);
            i_branch       = 2'($urandom);
            i_memRead      = ($urandom_range(0, 2) == 0);
            i_memWrite     = 1'($urandom);
            i_memtoReg     = 1'($urandom);
            i_regWrite     = 1'($urandom);
            i_valid        = ($urandom_range(0, 7) != 0);
            i_branch_taken = ($urandom_range(0, 7) == 0);
            i_halt         = 1'b0;
            $display("txn t=%0t rand ins=%h v=%b bt=%b mr=%b rw=%b", $time, ins, i_valid, i_branch_taken, i_memRead, i_regWrite);
            @(negedge i_clk);
            n_checks++; if (ex_v !== {pipe[0].aluop, pipe[0].alusrc, pipe[0].regdst}) $display("FAIL rand_ex: got %b want %b", ex_v, {pipe[0].aluop, pipe[0].alusrc, pipe[0].regdst}); else n_pass++;
            n_checks++; if (m_v !== {pipe[1].br, pipe[1].mr, pipe[1].mw}) $display("FAIL rand_mem: got %b want %b", m_v, {pipe[1].br, pipe[1].mr, pipe[1].mw}); else n_pass++;
            n_checks++; if ({wb_v, o_wb_rd} !== {pipe[2].m2r, pipe[2].rw, pipe[2].dest}) $display("FAIL rand_wb: got %b want %b", {wb_v, o_wb_rd}, {pipe[2].m2r, pipe[2].rw, pipe[2].dest}); else n_pass++;
            n_checks++; if ({o_fwd_a, o_fwd_b} !== {fwd_of(pipe[0].rs), fwd_of(pipe[0].rt)}) $display("FAIL rand_fwd: got %b want %b", {o_fwd_a, o_fwd_b}, {fwd_of(pipe[0].rs), fwd_of(pipe[0].rt)}); else n_pass++;
            n_checks++; if ({o_stall, o_flush} !== {m_stall, i_branch_taken}) $display("FAIL rand_hazard: got %b want %b", {o_stall, o_flush}, {m_stall, i_branch_taken}); else n_pass++;
            n_checks++; if (o_halted !== (m_halted | pipe[2].h)) $display("FAIL rand_halted: got %b want %b", o_halted, m_halted | pipe[2].h); else n_pass++;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b1;
        i_branch_taken = 1'b0;
    endtask

    task automatic test_halt();
        logic [4:0] vseq;
        logic [4:0] hseq;
        vseq = 5'b11101;
        hseq = 5'b10000;
        i_branch_taken = 1'b0;
        nop();
        i_halt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_valid = vseq[k];
            #1;
            n_checks++; if (o_stall !== 1'b1) $display("FAIL halt_stall_c%0d: got %b want 1", k, o_stall); else n_pass++;
            n_checks++; if (o_halted !== hseq[k]) $display("FAIL halt_done_c%0d: got %b want %b", k, o_halted, hseq[k]); else n_pass++;
            adv();
        end
        i_valid = 1'b1;
        i_halt  = 1'b0;
        #1;
        n_checks++; if ({o_stall, o_halted} !== 2'b11) $display("FAIL halt_sticky: got stall=%b halted=%b want 1 1", o_stall, o_halted); else n_pass++;
        i_reset = 1'b0;
        #1;
        n_checks++; if (all_out !== '0) $display("FAIL halt_reset: got %h want 0", all_out); else n_pass++;
        #1;
        i_reset = 1'b1;
        adv();
    endtask

    initial begin
        nop();
        test_reset();
        test_rtype();
        test_load_use();
        test_forward();
        test_flush();
        test_reset_midstream();
        test_random();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
